hex_digit_counter: RTL and testbench
====================================

# hex_digit_counter

Rate-divided 4-bit hex counter that produces the digit consumed by the board's 7-segment decoder. It drives that decoder's 4-bit input, replacing the switch inputs, so a HEX display shows a digit stepping at a selectable rate. Supported actions:
- count up or down
- parallel load
- pause via enable

It also emits per-step and wrap pulses so further digits can be cascaded.

## Interface

Parameters:
- TICK — default 50_000_000 — clock cycles in the 1 Hz base period; benches override with a small value such as 4.
- DIV_W — default 28 — divider register width; must satisfy 4*TICK-1 < 2**DIV_W.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = divider runs and the digit may step; 0 = divider and digit hold.
- speed  in  2  step period:
  - 00 = every clock
  - 01 = TICK cycles
  - 10 = 2*TICK cycles
  - 11 = 4*TICK cycles
- up  in  1  1 = increment, 0 = decrement.
- load  in  1  parallel-load strobe.
- load_val  in  4  value written on load.
- digit  out  4  current hex digit; feeds the 7-segment decoder.
- tick  out  1  one-cycle pulse, high in the first cycle digit shows a stepped value.
- wrap  out  1  one-cycle pulse with tick when the step crossed F->0 (up) or 0->F (down).

## Operation

- Registers:
  - div (DIV_W bits), a down-counter.
  - speed_q, the registered speed.
  - digit, tick and wrap; all outputs are registered.
- P(speed) = 1, TICK, 2*TICK or 4*TICK; reload value R = P-1.
- Per-edge priority is reset > load > speed change > enable.
- reset:
  - digit=0, tick=0, wrap=0.
  - div=R(speed), speed_q=speed.
- load:
  - digit=load_val, div=R(speed), tick=0, wrap=0.
  - This restarts the step phase. It applies regardless of enable.
- Speed change (speed != speed_q, no load):
  - div=R(speed), speed_q=speed, no step, tick=0, wrap=0.
- Otherwise, expire = enable & (div==0):
  - expire: div=R(speed); digit=digit+1 mod 16 if up, else digit-1 mod 16; tick=1; wrap=1 if digit was F with up=1, or 0 with up=0.
  - enable & div!=0: div=div-1, tick=0, wrap=0.
  - enable=0: div and digit hold; tick=0, wrap=0.
- up is sampled only on the expiring edge; changing it mid-period has no other effect.
- Arithmetic is 4-bit modular. There is no saturation and no illegal digit values.

## Timing

- speed=00: div is always 0, so digit steps on every edge while enable=1; tick stays high continuously.
- Other speeds: with enable held high, consecutive digit changes are exactly P cycles apart.
  - The first step after reset, load or a speed change lands on the P-th edge after that event's edge.
- Pausing:
  - enable low for N cycles delays the next step by exactly N cycles.
  - Divider phase is preserved.
- Timing of load_val and reset:
  - load_val appears on digit in the cycle after the load edge.
  - Reset mid-count takes effect at the next edge, with no partial step.
- load is level-sensitive: while it is held, digit tracks load_val every cycle and no step occurs.
- tick and wrap are never high in the cycle after reset, load or a speed change.
- The downstream decoder is combinational, so display latency from a step is 0 cycles beyond digit.

## Test plan

- TICK=4, reset, speed=00, up=1, enable=1:
  - digit reads 1,2,...,F,0 on successive cycles.
  - wrap=1 only in the cycle digit=0 after F; tick high throughout.
- TICK=4, speed=01:
  - digit steps every 4 cycles (0→1 on the 4th edge after reset).
  - Switching to speed=11 mid-period: the next step lands 16 cycles after the change edge.
- TICK=4, up=0 from reset, speed=01:
  - First step gives digit=F with wrap=1 and tick=1.
  - Next step gives E with wrap=0.
- load=1 with load_val=9 two cycles into a 4-cycle period:
  - Next cycle digit=9, tick=0.
  - Next step to A exactly 4 cycles after the load edge.
- Pause and reset:
  - enable=0 for 3 cycles at div=2: digit holds, and the step is delayed by exactly 3 cycles.
  - reset=1 while digit=7: digit=0, tick=0, wrap=0 on the next edge.

Source files
------------

// File: rtl/hex_digit_counter_if.sv
// hex_digit_counter_if: control inputs and digit/pulse outputs of the hex digit counter
interface hex_digit_counter_if;
  logic       enable;
  logic [1:0] speed;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] digit;
  logic       tick;
  logic       wrap;
  modport master (output enable, speed, up, load, load_val, input digit, tick, wrap);
  modport slave (input enable, speed, up, load, load_val, output digit, tick, wrap);
endinterface

// File: rtl/hex_digit_counter.sv
// hex_digit_counter: rate-divided up/down hex digit with load, pause and cascade pulses
module hex_digit_counter #(
  parameter int TICK  = 50_000_000,
  parameter int DIV_W = 28
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  hex_digit_counter_if.slave  bus
);
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_speed;
  logic [3:0]       r_digit;
  logic             r_tick;
  logic             r_wrap;
  logic [DIV_W-1:0] w_reload;
  logic             w_expire;
  logic             w_cross;
  logic [3:0]       w_next;
  // Divider reload for the requested step period, plus the step/wrap decision
  always_comb begin
    w_reload = bus.speed == 2'd0 ? '0 :
               bus.speed == 2'd1 ? DIV_W'(TICK - 1) :
               bus.speed == 2'd2 ? DIV_W'(2 * TICK - 1) : DIV_W'(4 * TICK - 1);
    w_expire = bus.enable && r_div == '0;
    w_cross  = bus.up ? r_digit == 4'hF : r_digit == 4'h0;
    w_next   = bus.up ? r_digit + 4'd1 : r_digit - 4'd1;
  end
  // Priority: reset, then load, then a speed change restarts the phase, else count
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_digit <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_div   <= w_reload;
      r_speed <= bus.speed;
    end else if (bus.load) begin
      r_digit <= bus.load_val;
      r_div   <= w_reload;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (bus.speed != r_speed) begin
      r_div   <= w_reload;
      r_speed <= bus.speed;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= w_expire;
      r_wrap <= w_expire && w_cross;
      if (w_expire) begin
        r_div   <= w_reload;
        r_digit <= w_next;
      end else if (bus.enable) begin
        r_div <= r_div - DIV_W'(1);
      end
    end
  end
  assign bus.digit = r_digit;
  assign bus.tick  = r_tick;
  assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_hex_digit_counter.sv
// tb_hex_digit_counter: directed stimulus with a queued scoreboard of per-cycle digit/tick/wrap
module tb_hex_digit_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  hex_digit_counter_if bus();
  hex_digit_counter #(.TICK(4), .DIV_W(8)) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  // Monitor: every settled cycle with a pending expectation is compared
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({bus.digit, bus.tick, bus.wrap} !== mon_e) begin
        errors++;
        $display("FAIL chk%0d: got digit=%h tick=%b wrap=%b, expected digit=%h tick=%b wrap=%b",
                 checks, bus.digit, bus.tick, bus.wrap, mon_e[5:2], mon_e[1], mon_e[0]);
      end
    end
  end
  task automatic cyc(input logic r, input logic en, input logic [1:0] sp, input logic u,
                     input logic ld, input logic [3:0] lv, input logic [3:0] ed,
                     input logic et, input logic ew);
    rst = r;
    bus.enable = en;
    bus.speed = sp;
    bus.up = u;
    bus.load = ld;
    bus.load_val = lv;
    @(posedge clk);
    #1;
    exp_q.push_back({ed, et, ew});
  endtask
  task automatic run1(input logic [1:0] sp, input logic u, input int n, input logic [3:0] ed);
    for (int i = 0; i < n; i++) cyc(0, 1, sp, u, 0, 0, ed, 0, 0);
  endtask
  initial begin
    // every-clock stepping, full wrap
    cyc(1, 1, 0, 1, 0, 0, 4'h0, 0, 0);
    for (int s = 1; s <= 16; s++) cyc(0, 1, 0, 1, 0, 0, 4'(s), 1, s == 16);
    // TICK period, then switch to 4*TICK mid-period
    cyc(1, 1, 1, 1, 0, 0, 4'h0, 0, 0);
    for (int s = 1; s <= 2; s++) begin
      run1(1, 1, 3, 4'(s - 1));
      cyc(0, 1, 1, 1, 0, 0, 4'(s), 1, 0);
    end
    run1(1, 1, 1, 4'h2);
    cyc(0, 1, 3, 1, 0, 0, 4'h2, 0, 0);
    run1(3, 1, 15, 4'h2);
    cyc(0, 1, 3, 1, 0, 0, 4'h3, 1, 0);
    // count down from reset wraps 0 -> F
    cyc(1, 1, 1, 0, 0, 0, 4'h0, 0, 0);
    run1(1, 0, 3, 4'h0);
    cyc(0, 1, 1, 0, 0, 0, 4'hF, 1, 1);
    run1(1, 0, 3, 4'hF);
    cyc(0, 1, 1, 0, 0, 0, 4'hE, 1, 0);
    // load two cycles into a period restarts the phase
    cyc(1, 1, 1, 1, 0, 0, 4'h0, 0, 0);
    run1(1, 1, 2, 4'h0);
    cyc(0, 1, 1, 1, 1, 4'h9, 4'h9, 0, 0);
    run1(1, 1, 3, 4'h9);
    cyc(0, 1, 1, 1, 0, 0, 4'hA, 1, 0);
    // held load tracks load_val, load works while paused
    cyc(0, 1, 1, 1, 1, 4'h5, 4'h5, 0, 0);
    cyc(0, 1, 1, 1, 1, 4'hC, 4'hC, 0, 0);
    run1(1, 1, 3, 4'hC);
    cyc(0, 1, 1, 1, 0, 0, 4'hD, 1, 0);
    cyc(0, 0, 1, 1, 1, 4'h3, 4'h3, 0, 0);
    run1(1, 1, 3, 4'h3);
    cyc(0, 1, 1, 1, 0, 0, 4'h4, 1, 0);
    // pause at div=2 delays the step by exactly the pause length
    cyc(1, 1, 1, 1, 0, 0, 4'h0, 0, 0);
    run1(1, 1, 1, 4'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0, 4'h0, 0, 0);
    run1(1, 1, 2, 4'h0);
    cyc(0, 1, 1, 1, 0, 0, 4'h1, 1, 0);
    for (int s = 2; s <= 7; s++) begin
      run1(1, 1, 3, 4'(s - 1));
      cyc(0, 1, 1, 1, 0, 0, 4'(s), 1, 0);
    end
    // reset at digit 7 beats a simultaneous load, no partial step
    cyc(1, 1, 1, 1, 1, 4'h9, 4'h0, 0, 0);
    run1(1, 1, 3, 4'h0);
    cyc(0, 1, 1, 1, 0, 0, 4'h1, 1, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
